// File: rtl/hand_track_filter.sv
// Per-frame hand tracker: bounding box, centre history, next-centre prediction and swipe gesture.
// Optional macro TRACK_EMA_EN smooths the tracked centre with a 1/4-weight exponential filter.
module hand_track_filter #(
  parameter int HIST_DEPTH  = 4,
  parameter int SWIPE_THRES = 64,
  parameter int MISS_LIMIT  = 3,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [10:0] i_up_x,
  input  logic [10:0] i_up_y,
  input  logic [10:0] i_left_x,
  input  logic [10:0] i_left_y,
  input  logic [10:0] i_right_x,
  input  logic [10:0] i_right_y,
  input  logic [10:0] i_down_x,
  input  logic [10:0] i_down_y,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_track,
  output logic [10:0] o_cx,
  output logic [10:0] o_cy,
  output logic [10:0] o_w,
  output logic [10:0] o_h,
  output logic [10:0] o_pred_x,
  output logic [10:0] o_pred_y,
  output logic [2:0]  o_gesture
);

  localparam int PW = $clog2(HIST_DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [10:0]   NOT_FOUND = 11'd2023;
  localparam logic [CW-1:0] FULL_CNT  = CW'(HIST_DEPTH);
  localparam logic [MW-1:0] MISS_MAX  = MW'(MISS_LIMIT);
  localparam logic [11:0]   THRES     = 12'(SWIPE_THRES);
  localparam logic [10:0]   X_MAX     = 11'(WIDTH - 1);
  localparam logic [10:0]   Y_MAX     = 11'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_PUSH = 3'd2,
    S_EVAL = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  function automatic logic [10:0] clamp_coord(input logic signed [12:0] v, input logic [10:0] vmax);
    logic [10:0] r;
    if (v < 13'sd0) r = 11'd0;
    else if (v > $signed({2'b00, vmax})) r = vmax;
    else r = v[10:0];
    return r;
  endfunction

  function automatic logic [11:0] abs12(input logic signed [11:0] v);
    logic [11:0] r;
    if (v[11]) r = $unsigned(-v);
    else r = $unsigned(v);
    return r;
  endfunction

  state_t        state_r, state_s;
  logic          miss_r, track_r;
  logic [10:0]   up_y_r, down_y_r, left_x_r, right_x_r;
  logic [10:0]   raw_cx_r, raw_cy_r, cen_x_r, cen_y_r, w_r, h_r;
  logic [MW-1:0] miss_cnt_r, miss_inc_s;
  logic [CW-1:0] cnt_r;
  logic [PW-1:0] wr_ptr_r, new_idx_s, prev_idx_s;
  logic [10:0]   hist_x_r [HIST_DEPTH];
  logic [10:0]   hist_y_r [HIST_DEPTH];

  logic [11:0]        sum_x_s, sum_y_s, w_s, h_s, adx_s, ady_s;
  logic signed [11:0] dx_s, dy_s;
  logic signed [12:0] px_s, py_s;
  logic [10:0]        push_x_s, push_y_s, pred_x_s, pred_y_s;
  logic [2:0]         gest_s;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_valid) state_s = S_CALC;
        else state_s = S_IDLE;
      end
      S_CALC:  state_s = S_PUSH;
      S_PUSH:  state_s = S_EVAL;
      S_EVAL:  state_s = S_OUT;
      S_OUT:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Box geometry and saturating miss-count increment
  always_comb begin
    sum_x_s = {1'b0, left_x_r} + {1'b0, right_x_r};
    sum_y_s = {1'b0, up_y_r} + {1'b0, down_y_r};
    w_s     = {1'b0, right_x_r} - {1'b0, left_x_r} + 12'd1;
    h_s     = {1'b0, down_y_r} - {1'b0, up_y_r} + 12'd1;
    if (miss_cnt_r == MISS_MAX) miss_inc_s = MISS_MAX;
    else miss_inc_s = miss_cnt_r + MW'(1);
  end

`ifdef TRACK_EMA_EN
  logic               ema_ok_r;
  logic signed [12:0] ema_dx_s, ema_dy_s, ema_x_s, ema_y_s;

  // Smoothed centre; the first hit after reset or a track drop seeds the filter
  always_comb begin
    ema_dx_s = $signed({2'b00, raw_cx_r}) - $signed({2'b00, cen_x_r});
    ema_dy_s = $signed({2'b00, raw_cy_r}) - $signed({2'b00, cen_y_r});
    ema_x_s  = $signed({2'b00, cen_x_r}) + (ema_dx_s >>> 2);
    ema_y_s  = $signed({2'b00, cen_y_r}) + (ema_dy_s >>> 2);
    if (ema_ok_r) begin
      push_x_s = ema_x_s[10:0];
      push_y_s = ema_y_s[10:0];
    end else begin
      push_x_s = raw_cx_r;
      push_y_s = raw_cy_r;
    end
  end

  logic unused_ema;
  assign unused_ema = ^{ema_x_s[12:11], ema_y_s[12:11]};
`else
  // Raw centre goes straight into the history
  always_comb begin
    push_x_s = raw_cx_r;
    push_y_s = raw_cy_r;
  end
`endif

  // Gesture classification and prediction from the history window
  always_comb begin
    new_idx_s  = wr_ptr_r - PW'(1);
    prev_idx_s = wr_ptr_r - PW'(2);
    dx_s  = $signed({1'b0, hist_x_r[new_idx_s]}) - $signed({1'b0, hist_x_r[wr_ptr_r]});
    dy_s  = $signed({1'b0, hist_y_r[new_idx_s]}) - $signed({1'b0, hist_y_r[wr_ptr_r]});
    adx_s = abs12(dx_s);
    ady_s = abs12(dy_s);
    gest_s = 3'd0;
    if (!miss_r && cnt_r == FULL_CNT) begin
      if (adx_s >= THRES && adx_s >= ady_s) gest_s = dx_s[11] ? 3'd2 : 3'd1;
      else if (ady_s >= THRES) gest_s = dy_s[11] ? 3'd4 : 3'd3;
      else gest_s = 3'd0;
    end else begin
      gest_s = 3'd0;
    end
    if (cnt_r >= CW'(2)) begin
      px_s = $signed({2'b00, hist_x_r[new_idx_s]}) + $signed({2'b00, hist_x_r[new_idx_s]})
           - $signed({2'b00, hist_x_r[prev_idx_s]});
      py_s = $signed({2'b00, hist_y_r[new_idx_s]}) + $signed({2'b00, hist_y_r[new_idx_s]})
           - $signed({2'b00, hist_y_r[prev_idx_s]});
    end else begin
      px_s = $signed({2'b00, cen_x_r});
      py_s = $signed({2'b00, cen_y_r});
    end
    pred_x_s = clamp_coord(px_s, X_MAX);
    pred_y_s = clamp_coord(py_s, Y_MAX);
  end

  // Frame pipeline: latch, calculate, push, evaluate, publish
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= S_IDLE;
      miss_r     <= 1'b0;
      track_r    <= 1'b0;
      up_y_r     <= 11'd0;
      down_y_r   <= 11'd0;
      left_x_r   <= 11'd0;
      right_x_r  <= 11'd0;
      raw_cx_r   <= 11'd0;
      raw_cy_r   <= 11'd0;
      cen_x_r    <= 11'd0;
      cen_y_r    <= 11'd0;
      w_r        <= 11'd0;
      h_r        <= 11'd0;
      miss_cnt_r <= {MW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_x_r[i] <= 11'd0;
        hist_y_r[i] <= 11'd0;
      end
`ifdef TRACK_EMA_EN
      ema_ok_r   <= 1'b0;
`endif
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_track    <= 1'b0;
      o_cx       <= 11'd0;
      o_cy       <= 11'd0;
      o_w        <= 11'd0;
      o_h        <= 11'd0;
      o_pred_x   <= 11'd0;
      o_pred_y   <= 11'd0;
      o_gesture  <= 3'd0;
    end else begin
      state_r <= state_s;
      o_busy  <= (state_s != S_IDLE);
      o_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_valid) begin
            miss_r    <= (i_up_y == NOT_FOUND) || (i_left_x == NOT_FOUND);
            up_y_r    <= i_up_y;
            down_y_r  <= i_down_y;
            left_x_r  <= i_left_x;
            right_x_r <= i_right_x;
          end
        end
        S_CALC: begin
          if (!miss_r) begin
            raw_cx_r   <= sum_x_s[11:1];
            raw_cy_r   <= sum_y_s[11:1];
            w_r        <= w_s[10:0];
            h_r        <= h_s[10:0];
            miss_cnt_r <= {MW{1'b0}};
          end else begin
            miss_cnt_r <= miss_inc_s;
            if (miss_inc_s == MISS_MAX) begin
              cnt_r    <= {CW{1'b0}};
              track_r  <= 1'b0;
`ifdef TRACK_EMA_EN
              ema_ok_r <= 1'b0;
`endif
            end
          end
        end
        S_PUSH: begin
          if (!miss_r) begin
            hist_x_r[wr_ptr_r] <= push_x_s;
            hist_y_r[wr_ptr_r] <= push_y_s;
            wr_ptr_r <= wr_ptr_r + PW'(1);
            if (cnt_r != FULL_CNT) cnt_r <= cnt_r + CW'(1);
            track_r <= 1'b1;
            cen_x_r <= push_x_s;
            cen_y_r <= push_y_s;
`ifdef TRACK_EMA_EN
            ema_ok_r <= 1'b1;
`endif
          end
        end
        S_EVAL: begin
          o_valid   <= 1'b1;
          o_track   <= track_r;
          o_cx      <= cen_x_r;
          o_cy      <= cen_y_r;
          o_w       <= w_r;
          o_h       <= h_r;
          o_pred_x  <= pred_x_s;
          o_pred_y  <= pred_y_s;
          o_gesture <= gest_s;
          // A reported swipe restarts the window so the next one needs fresh samples
          if (gest_s != 3'd0) cnt_r <= {CW{1'b0}};
        end
        S_OUT: begin
        end
        default: begin
        end
      endcase
    end
  end

  logic unused_in;
  assign unused_in = ^{i_up_x, i_left_y, i_right_y, i_down_x,
                       sum_x_s[0], sum_y_s[0], w_s[11], h_s[11]};

endmodule

// File: tb/tb_hand_track_filter.sv
// Self-checking bench for hand_track_filter: directed table, timing corner cases and
// randomized frames against a queue-based reference model.
module tb_hand_track_filter;
  localparam int HD = 4, THR = 64, ML = 3, WD = 640, HT = 480;

  logic clk = 1'b0;
  logic rst, vld;
  logic [10:0] up_x, up_y, left_x, left_y, right_x, right_y, down_x, down_y;
  logic busy, ovld, trk;
  logic [10:0] cx, cy, w, h, px, py;
  logic [2:0] gest;

  always #5 clk = ~clk;

  hand_track_filter #(.HIST_DEPTH(HD), .SWIPE_THRES(THR), .MISS_LIMIT(ML), .WIDTH(WD), .HEIGHT(HT)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld),
    .i_up_x(up_x), .i_up_y(up_y), .i_left_x(left_x), .i_left_y(left_y),
    .i_right_x(right_x), .i_right_y(right_y), .i_down_x(down_x), .i_down_y(down_y),
    .o_busy(busy), .o_valid(ovld), .o_track(trk), .o_cx(cx), .o_cy(cy), .o_w(w), .o_h(h),
    .o_pred_x(px), .o_pred_y(py), .o_gesture(gest)
  );

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int hx[$], hy[$];
  int m_miss, m_trk, m_cx, m_cy, m_w, m_h, e_px, e_py, e_g;
  bit m_ema_ok;

  function automatic int clampi(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  task automatic model_reset();
    hx.delete(); hy.delete();
    m_miss = 0; m_trk = 0; m_cx = 0; m_cy = 0; m_w = 0; m_h = 0;
    e_px = 0; e_py = 0; e_g = 0; m_ema_ok = 0;
  endtask

  task automatic model_frame(input int u, input int l, input int r, input int d);
    bit miss;
    int ncx, ncy, dxv, dyv, adx, ady, pxv, pyv;
    miss = (u == 2023) || (l == 2023);
    if (!miss) begin
      ncx = (l + r) / 2;
      ncy = (u + d) / 2;
      m_w = (r - l + 1) & 2047;
      m_h = (d - u + 1) & 2047;
      m_miss = 0;
`ifdef TRACK_EMA_EN
      if (m_ema_ok) begin
        m_cx = m_cx + ((ncx - m_cx) >>> 2);
        m_cy = m_cy + ((ncy - m_cy) >>> 2);
      end else begin
        m_cx = ncx; m_cy = ncy;
      end
      m_ema_ok = 1;
`else
      m_cx = ncx; m_cy = ncy;
`endif
      hx.push_back(m_cx); hy.push_back(m_cy);
      if (hx.size() > HD) begin
        void'(hx.pop_front()); void'(hy.pop_front());
      end
      m_trk = 1;
    end else begin
      if (m_miss < ML) m_miss++;
      if (m_miss == ML) begin
        hx.delete(); hy.delete(); m_trk = 0; m_ema_ok = 0;
      end
    end
    e_g = 0;
    if (!miss && hx.size() == HD) begin
      dxv = hx[HD-1] - hx[0];
      dyv = hy[HD-1] - hy[0];
      adx = (dxv < 0) ? -dxv : dxv;
      ady = (dyv < 0) ? -dyv : dyv;
      if (adx >= THR && adx >= ady) e_g = (dxv > 0) ? 1 : 2;
      else if (ady >= THR) e_g = (dyv > 0) ? 3 : 4;
    end
    if (hx.size() >= 2) begin
      pxv = 2 * hx[hx.size()-1] - hx[hx.size()-2];
      pyv = 2 * hy[hy.size()-1] - hy[hy.size()-2];
    end else begin
      pxv = m_cx; pyv = m_cy;
    end
    e_px = clampi(pxv, WD - 1);
    e_py = clampi(pyv, HT - 1);
    if (e_g != 0) begin
      hx.delete(); hy.delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".cx"}, cx, m_cx);
    chk({tag, ".cy"}, cy, m_cy);
    chk({tag, ".w"}, w, m_w);
    chk({tag, ".h"}, h, m_h);
    chk({tag, ".pred_x"}, px, e_px);
    chk({tag, ".pred_y"}, py, e_py);
    chk({tag, ".gesture"}, gest, e_g);
    chk({tag, ".track"}, trk, m_trk);
  endtask

  task automatic drive_coords(input int u, input int l, input int r, input int d);
    up_y = 11'(u); left_x = 11'(l); right_x = 11'(r); down_y = 11'(d);
    up_x = 11'($urandom_range(0, 2047)); down_x = 11'($urandom_range(0, 2047));
    left_y = 11'($urandom_range(0, 2047)); right_y = 11'($urandom_range(0, 2047));
  endtask

  // One frame: pulse, measure latency and busy window, compare against the model.
  task automatic send_frame(input int l, input int r, input int u, input int d, input bit noise);
    int n;
    bit got, busy_ok;
    @(negedge clk);
    drive_coords(u, l, r, d);
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    model_frame(u, l, r, d);
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      if (!busy && n <= 4) busy_ok = 1'b0;
      if (ovld) got = 1'b1;
      else if (noise) begin
        drive_coords($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047));
        vld = 1'($urandom_range(0, 1));
      end
    end
    vld = 1'b0;
    if (!got) chk("latency_timeout", n, 4);
    else chk("latency", n, 4);
    chk("busy_window", busy_ok, 1);
    @(negedge clk);
    chk("valid_pulse", ovld, 0);
    check_outputs("frame");
  endtask

  typedef struct {
    int l, r, u, d;
    int ecx, ecy, ew, eh, epx, epy, eg, etrk;
  } vec_t;
  vec_t tbl [14];

  initial begin
    int bx, by, vx, vy, l, r, u, d;
    bit vseen [14];
    bit stray;

    tbl[0]  = '{80, 120, 220, 260, 100, 240, 41, 41, 100, 240, 0, 1};
    tbl[1]  = '{120, 160, 220, 260, 140, 240, 41, 41, 180, 240, 0, 1};
    tbl[2]  = '{160, 200, 220, 260, 180, 240, 41, 41, 220, 240, 0, 1};
    tbl[3]  = '{200, 240, 220, 260, 220, 240, 41, 41, 260, 240, 1, 1};
    tbl[4]  = '{240, 280, 220, 260, 260, 240, 41, 41, 260, 240, 0, 1};
    tbl[5]  = '{240, 280, 2023, 260, 260, 240, 41, 41, 260, 240, 0, 1};
    tbl[6]  = '{240, 280, 2023, 260, 260, 240, 41, 41, 260, 240, 0, 1};
    tbl[7]  = '{240, 280, 2023, 260, 260, 240, 41, 41, 260, 240, 0, 0};
    tbl[8]  = '{280, 320, 220, 260, 300, 240, 41, 41, 300, 240, 0, 1};
    tbl[9]  = '{580, 620, 220, 260, 600, 240, 41, 41, 639, 240, 0, 1};
    tbl[10] = '{610, 650, 220, 260, 630, 240, 41, 41, 639, 240, 0, 1};
    tbl[11] = '{0, 40, 220, 260, 20, 240, 41, 41, 0, 240, 2, 1};
    tbl[12] = '{0, 40, 220, 260, 20, 240, 41, 41, 20, 240, 0, 1};
    tbl[13] = '{0, 10, 220, 260, 5, 240, 11, 41, 0, 240, 0, 1};

    rst = 1'b1; vld = 1'b0;
    drive_coords(0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.valid", ovld, 0);
    check_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      send_frame(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d, 1'b0);
`ifndef TRACK_EMA_EN
      chk($sformatf("tbl%0d.cx", i), cx, tbl[i].ecx);
      chk($sformatf("tbl%0d.cy", i), cy, tbl[i].ecy);
      chk($sformatf("tbl%0d.w", i), w, tbl[i].ew);
      chk($sformatf("tbl%0d.h", i), h, tbl[i].eh);
      chk($sformatf("tbl%0d.pred_x", i), px, tbl[i].epx);
      chk($sformatf("tbl%0d.pred_y", i), py, tbl[i].epy);
      chk($sformatf("tbl%0d.gesture", i), gest, tbl[i].eg);
      chk($sformatf("tbl%0d.track", i), trk, tbl[i].etrk);
`endif
    end

    // Busy rejection: pulses in cycles 0, 2 and 5; results expected in cycles 4 and 9
    drive_coords(220, 80, 120, 260);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      vseen[c] = ovld;
      vld = (c == 0 || c == 2 || c == 5);
    end
    vld = 1'b0;
    for (int c = 1; c < 14; c++) chk($sformatf("busy_rej.valid_c%0d", c), vseen[c], (c == 4 || c == 9) ? 1 : 0);
    model_frame(220, 80, 120, 260);
    model_frame(220, 80, 120, 260);
    check_outputs("busy_rej");

    // Reset in cycle 2 of a frame: outputs cleared in cycle 3, no result strobe
    stray = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("midrst.busy", busy, 0);
        check_outputs("midrst_pre");
      end
      if (c > 0 && ovld) stray = 1'b1;
      vld = (c == 0);
      rst = (c == 2);
      if (c == 2) model_reset();
    end
    vld = 1'b0; rst = 1'b0;
    chk("midrst.no_valid", stray, 0);

    send_frame(80, 120, 220, 260, 1'b0);
    send_frame(180, 220, 220, 260, 1'b0);
`ifdef TRACK_EMA_EN
    chk("ema.second_cx", cx, 125);
`else
    chk("raw.second_cx", cx, 200);
    chk("raw.second_pred_x", px, 300);
`endif

    bx = 300; by = 200; vx = 25; vy = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        vx = int'($urandom_range(0, 80)) - 40;
        vy = int'($urandom_range(0, 80)) - 40;
      end
      bx = clampi(bx + vx + int'($urandom_range(0, 10)) - 5, 1800);
      by = clampi(by + vy + int'($urandom_range(0, 10)) - 5, 1800);
      l = bx; r = bx + int'($urandom_range(0, 120));
      u = by; d = by + int'($urandom_range(0, 120));
      if ($urandom_range(0, 99) < 25) begin
        if ($urandom_range(0, 1) == 1) u = 2023;
        else l = 2023;
      end
      send_frame(l, r, u, d, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
